// File: rtl/pipe_stage_register.sv
// Generic inter-stage pipeline register with valid/ready handshake, synchronous flush
// and an optional skid entry that registers In_Ready.
module pipe_stage_register #(
  parameter int unsigned CTRL_W = 3,
  parameter int unsigned DATA_W = 101,
  parameter int unsigned SKID   = 1
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              In_Valid,
  output logic              In_Ready,
  input  logic [CTRL_W-1:0] In_Ctrl,
  input  logic [DATA_W-1:0] In_Data,
  input  logic              Flush,
  output logic              Out_Valid,
  input  logic              Out_Ready,
  output logic [CTRL_W-1:0] Out_Ctrl,
  output logic [DATA_W-1:0] Out_Data,
  output logic [1:0]        Occupancy
);

  localparam bit UseSkid = (SKID != 0);

  logic              m_valid_q, m_valid_d;
  logic [CTRL_W-1:0] m_ctrl_q, m_ctrl_d;
  logic [DATA_W-1:0] m_data_q, m_data_d;
  logic              s_valid_q, s_valid_d;
  logic [CTRL_W-1:0] s_ctrl_q, s_ctrl_d;
  logic [DATA_W-1:0] s_data_q, s_data_d;
  logic              in_ready_q, in_ready_d;
  logic              accept;
  logic              drain;

  assign drain    = m_valid_q & Out_Ready;
  assign In_Ready = UseSkid ? in_ready_q : (~m_valid_q | Out_Ready);
  assign accept   = In_Valid & In_Ready;

  always_comb begin
    m_valid_d = m_valid_q;
    m_ctrl_d  = m_ctrl_q;
    m_data_d  = m_data_q;
    s_valid_d = s_valid_q;
    s_ctrl_d  = s_ctrl_q;
    s_data_d  = s_data_q;

    if (Flush) begin
      // A drain this cycle was already sampled downstream; an accept is dropped.
      m_valid_d = 1'b0;
      m_ctrl_d  = '0;
      s_valid_d = 1'b0;
      s_ctrl_d  = '0;
    end else if (UseSkid && s_valid_q) begin
      // In_Ready is low here, so only the skid-to-main move can happen.
      if (drain) begin
        m_valid_d = 1'b1;
        m_ctrl_d  = s_ctrl_q;
        m_data_d  = s_data_q;
        s_valid_d = 1'b0;
        s_ctrl_d  = '0;
      end
    end else if (accept) begin
      if (!m_valid_q || drain) begin
        m_valid_d = 1'b1;
        m_ctrl_d  = In_Ctrl;
        m_data_d  = In_Data;
      end else if (UseSkid) begin
        s_valid_d = 1'b1;
        s_ctrl_d  = In_Ctrl;
        s_data_d  = In_Data;
      end
    end else if (drain) begin
      m_valid_d = 1'b0;
      m_ctrl_d  = '0;
    end

    in_ready_d = ~s_valid_d;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      m_valid_q  <= 1'b0;
      m_ctrl_q   <= '0;
      m_data_q   <= '0;
      s_valid_q  <= 1'b0;
      s_ctrl_q   <= '0;
      s_data_q   <= '0;
      in_ready_q <= 1'b1;
    end else begin
      m_valid_q  <= m_valid_d;
      m_ctrl_q   <= m_ctrl_d;
      m_data_q   <= m_data_d;
      s_valid_q  <= s_valid_d;
      s_ctrl_q   <= s_ctrl_d;
      s_data_q   <= s_data_d;
      in_ready_q <= in_ready_d;
    end
  end

  // Stored ctrl is zeroed whenever an entry empties, so no output gating is needed.
  assign Out_Valid = m_valid_q;
  assign Out_Ctrl  = m_ctrl_q;
  assign Out_Data  = m_data_q;
  assign Occupancy = {1'b0, m_valid_q} + {1'b0, s_valid_q};

endmodule

// File: doc/pipe_stage_register.md
# pipe_stage_register

Generic, parametrised pipeline stage register that replaces the fixed inter-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB) with one block. It carries a control field and a data payload with a valid/ready handshake and a synchronous flush. An optional skid entry breaks the combinational path from `Out_Ready` to `In_Ready`. It sits between two adjacent pipeline stages: the upstream stage drives `In_*` and the downstream stage drives `Out_Ready`.

## Interface
- `CTRL_W`, default 3: width of the control field (e.g. register-write enable plus result-source select). Must be 1 or more.
- `DATA_W`, default 101: width of the payload (e.g. rd, ALU result, PC+4). Must be 1 or more.
- `SKID`, default 1: 1 adds a second entry so `In_Ready` is registered; 0 gives a single entry with combinational ready.
- `CLK` input 1: single clock; all state updates on the rising edge.
- `RST_N` input 1: reset, asynchronous and active-low.
- `In_Valid` input 1: upstream holds a valid instruction.
- `In_Ready` output 1: stage can accept this cycle.
- `In_Ctrl` input `CTRL_W`: upstream control field.
- `In_Data` input `DATA_W`: upstream payload.
- `Flush` input 1: synchronous kill of all held and incoming entries.
- `Out_Valid` output 1: the main entry is valid.
- `Out_Ready` input 1: downstream accepts this cycle.
- `Out_Ctrl` output `CTRL_W`: control field of the main entry; all zeros whenever `Out_Valid`=0.
- `Out_Data` output `DATA_W`: payload of the main entry.
- `Occupancy` output 2: number of valid entries (0, 1 or 2).

## Operation
- **Storage:** main entry (M) drives the outputs. When `SKID`=1 there is also a skid entry (S). Each entry holds valid, ctrl and data.
- **Handshakes:** accept occurs when `In_Valid` and `In_Ready` are both 1. Drain occurs when `Out_Valid` and `Out_Ready` are both 1.
- **`SKID`=0:**
  - `In_Ready` = !M.valid || `Out_Ready`.
  - On accept, M loads the input. On drain without accept, M.valid clears.
- **`SKID`=1:**
  - `In_Ready` = !S.valid, driven directly from a flop.
  - Accept while M is empty or draining: the input goes to M.
  - Accept while M is full and not draining: the input goes to S.
  - Drain while S is valid: M loads from S and S clears. A simultaneous accept is impossible here because `In_Ready`=0.
- **Ordering:** entries leave strictly in acceptance order. No entry is duplicated or dropped except on flush.
- **Flush:**
  - Highest priority.
  - Next cycle: M.valid=0, S.valid=0, all stored ctrl=0. Data is don't-care.
  - An accept in the flush cycle is discarded.
  - A drain in the flush cycle still counts as delivered downstream, because the downstream stage sampled it.
- **Control masking:** whenever an entry becomes invalid (drain with no refill, flush, reset), its ctrl is written to zero. A bubble therefore never carries a register-write enable.
- **Data:** each data field holds its value while its entry is stalled. Data loads only on a write into that entry.
- **Occupancy** = M.valid + S.valid (S.valid is 0 when `SKID`=0).

## Timing
- Latency: 1 cycle from accept to `Out_Valid`, when M is empty or draining. Add 1 cycle per stalled cycle.
- Throughput: 1 entry per cycle while `Out_Ready`=1, for both `SKID` values.
- `SKID`=1 path: no combinational path from `Out_Ready` to `In_Ready`. The only combinational outputs are the gated `Out_Ctrl` (or registered zeros) and `Occupancy`, both derived from flops.
- Reset (`RST_N`=0), asynchronous, takes effect immediately mid-operation:
  - `Out_Valid`=0, `Out_Ctrl`=0, `Out_Data`=0, `Occupancy`=0.
  - `In_Ready`=1 for `SKID`=1; for `SKID`=0 it follows its equation.
- Reset release: the first accept is possible on the first rising edge with `RST_N`=1.
- Full (`SKID`=1, `Occupancy`=2): `In_Ready`=0. It returns to 1 in the cycle after the first drain.
- Empty: `Out_Valid`=0, and `Out_Ready` is ignored.
- Simultaneous `Flush` and reset: reset dominates.

## Test plan
- **Reset mid-stream:** stream ctrl=3'b101, data=i for 4 cycles, then assert `RST_N`=0 mid-cycle. Required: outputs immediately go to `Out_Valid`=0, `Out_Ctrl`=0, `Occupancy`=0, with no clock edge needed.
- **Streaming:** `SKID`=1, `Out_Ready`=1, data 1..8 back-to-back. Required: `Out_Data`=1..8 on consecutive cycles starting 1 cycle after the first accept; `In_Ready` stays 1.
- **Backpressure:** `SKID`=1, accept A and B, hold `Out_Ready`=0. Required: `Occupancy`=2 and `In_Ready`=0; C is refused. Release `Out_Ready`: required order A, B, C with no loss.
- **Flush:** `Occupancy`=2 with ctrl=3'b111, then assert `Flush` together with `In_Valid`. Required: next cycle `Occupancy`=0, `Out_Ctrl`=0, `In_Ready`=1, and the flushed input never appears.
- **Drain without refill:** `SKID`=0, ctrl=3'b001 entry, drain with no new input. Required: next cycle `Out_Valid`=0 and `Out_Ctrl`=0.
- **Random ordering:** randomised `In_Valid`/`Out_Ready`/`Flush` for 10k cycles with a scoreboard, run at both `SKID` values. Required: every delivered item matches in order, and no ctrl bit is nonzero while `Out_Valid`=0.
